// File: rtl/ball_physics_if.sv
// Ball engine port bundle: paddle rows and serve in, ball position and
// score pulses out. The engine uses the slave modport; the game/testbench
// side uses master.
//
// Handshake: there is no valid/ready pair on this bundle. serve is a
// single-cycle request sampled on every clock and acted on only while the
// engine is parked (IDLE); it is dropped silently otherwise. l_score and
// r_score are one-cycle pulses with no acknowledge. Paddle rows and ball
// position are level signals that may be sampled on any cycle.
interface ball_physics_if;
  logic [11:0] l_center_row;
  logic [11:0] r_center_row;
  logic        serve;
  logic [11:0] ball_center_col;
  logic [11:0] ball_center_row;
  logic        ball_active;
  logic        l_score;
  logic        r_score;

  modport master (
    output l_center_row, r_center_row, serve,
    input  ball_center_col, ball_center_row, ball_active, l_score, r_score
  );

  modport slave (
    input  l_center_row, r_center_row, serve,
    output ball_center_col, ball_center_row, ball_active, l_score, r_score
  );
endinterface

// File: rtl/ball_physics.sv
// Pong ball motion engine: signed velocity vector, position-dependent paddle
// deflection, wall reflection, miss scoring and an IDLE/WAIT/PLAY serve FSM.
// Motion advances once per internal tick (TICK_DIV clk cycles).
// Optional feature macro: BALL_SPEEDUP_EN (each paddle hit raises the
// horizontal speed up to MAX_VX; every launch restarts at speed 1).
// SERVE_DELAY must be at least 1; MAX_VY must fit a 4-bit signed value.
module ball_physics #(
  parameter int DISP_COLS           = 800,
  parameter int DISP_ROWS           = 600,
  parameter int FIELD_BOTTOM        = DISP_ROWS - 40,
  parameter int P_HEIGHT            = 44,
  parameter int P_WIDTH             = 12,
  parameter int B_HEIGHT            = 8,
  parameter int B_WIDTH             = 6,
  parameter int L_PADDLE_CENTER_COL = 15,
  parameter int R_PADDLE_CENTER_COL = DISP_COLS - 15,
  parameter int TICK_DIV            = 100000,
  parameter int SERVE_DELAY         = 60,
  parameter int MAX_VY              = 3,
  parameter int MAX_VX              = 4,
  parameter int HIT_SHIFT           = 3
) (
  input  logic          clk,
  input  logic          rst,
  ball_physics_if.slave bus,
  output logic [1:0]    o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_PLAY = 2'd2
  } state_t;

  localparam int CNT_W  = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int WAIT_W = $clog2(SERVE_DELAY + 1);
  localparam int SPD_W  = $clog2(MAX_VX + 1);

  localparam logic [CNT_W-1:0]  TICK_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(SERVE_DELAY - 1);

  // Geometry in the signed 14-bit domain used for all position math.
  localparam logic signed [13:0] C_HB   = 14'(B_HEIGHT / 2);
  localparam logic signed [13:0] C_WB   = 14'(B_WIDTH / 2);
  localparam logic signed [13:0] C_HP   = 14'(P_HEIGHT / 2);
  localparam logic signed [13:0] C_LF   = 14'(L_PADDLE_CENTER_COL + P_WIDTH / 2);
  localparam logic signed [13:0] C_RF   = 14'(R_PADDLE_CENTER_COL - P_WIDTH / 2);
  localparam logic signed [13:0] C_FB   = 14'(FIELD_BOTTOM);
  localparam logic signed [13:0] C_COLS = 14'(DISP_COLS);
  localparam logic signed [13:0] C_MVY  = 14'(MAX_VY);

  localparam logic [11:0] C_HOME_COL = 12'(DISP_COLS / 2);
  localparam logic [11:0] C_HOME_ROW = 12'(DISP_ROWS / 2);
  localparam logic [11:0] C_TOP_ROW  = 12'(B_HEIGHT / 2);
  localparam logic [11:0] C_BOT_ROW  = 12'(FIELD_BOTTOM - B_HEIGHT / 2);
  localparam logic [11:0] C_L_BOUNCE = 12'(L_PADDLE_CENTER_COL + P_WIDTH / 2 + B_WIDTH / 2 + 1);
  localparam logic [11:0] C_R_BOUNCE = 12'(R_PADDLE_CENTER_COL - P_WIDTH / 2 - B_WIDTH / 2 - 1);

  localparam logic signed [3:0] C_VY_POS = 4'(MAX_VY);
  localparam logic signed [3:0] C_VY_NEG = 4'(-MAX_VY);

  // Saturate a deflection value to the vertical speed limit.
  function automatic logic signed [3:0] clamp_vy(input logic signed [13:0] v);
    if (v > C_MVY) begin
      clamp_vy = C_VY_POS;
    end else if (v < -C_MVY) begin
      clamp_vy = C_VY_NEG;
    end else begin
      clamp_vy = v[3:0];
    end
  endfunction

  // Registers
  state_t              r_state;
  logic [CNT_W-1:0]    r_tick_cnt;
  logic [WAIT_W-1:0]   r_wait_cnt;
  logic [11:0]         r_col;
  logic [11:0]         r_row;
  logic signed [3:0]   r_vy;
  logic                r_dir;
  logic                r_l_score;
  logic                r_r_score;

  // Next-state and datapath wires
  state_t              w_state_n;
  logic [WAIT_W-1:0]   w_wait_n;
  logic [11:0]         w_col_n;
  logic [11:0]         w_row_n;
  logic signed [3:0]   w_vy_n;
  logic                w_dir_n;
  logic                w_l_score_n;
  logic                w_r_score_n;

  logic                w_tick;
  logic                w_wait_done;
  logic [SPD_W-1:0]    w_speed;
  logic signed [13:0]  w_col_s;
  logic signed [13:0]  w_row_s;
  logic signed [13:0]  w_vy_s;
  logic signed [13:0]  w_spd_s;
  logic signed [13:0]  w_lc_s;
  logic signed [13:0]  w_rc_s;
  logic signed [13:0]  w_nc;
  logic signed [13:0]  w_nr;
  logic                w_l_ovl;
  logic                w_r_ovl;
  logic                w_l_hit;
  logic                w_r_hit;
  logic signed [3:0]   w_l_vy;
  logic signed [3:0]   w_r_vy;

  assign w_tick      = (r_tick_cnt == TICK_LAST);
  assign w_wait_done = (r_wait_cnt == WAIT_LAST);

  assign w_col_s = signed'({2'b00, r_col});
  assign w_row_s = signed'({2'b00, r_row});
  assign w_vy_s  = 14'(r_vy);
  assign w_spd_s = signed'(14'(w_speed));
  assign w_lc_s  = signed'({2'b00, bus.l_center_row});
  assign w_rc_s  = signed'({2'b00, bus.r_center_row});

  // Candidate position for this tick before walls/paddles are applied.
  assign w_nc = r_dir ? (w_col_s + w_spd_s) : (w_col_s - w_spd_s);
  assign w_nr = w_row_s + w_vy_s;

  // Paddle tests use the pre-move row; a hit needs the ball's leading edge
  // to cross the paddle face during this tick while the rows overlap.
  assign w_l_ovl = (w_row_s + C_HB >= w_lc_s - C_HP) && (w_row_s - C_HB <= w_lc_s + C_HP);
  assign w_r_ovl = (w_row_s + C_HB >= w_rc_s - C_HP) && (w_row_s - C_HB <= w_rc_s + C_HP);
  assign w_l_hit = !r_dir && (w_col_s - C_WB > C_LF) && (C_LF >= w_nc - C_WB) && w_l_ovl;
  assign w_r_hit = r_dir && (w_col_s + C_WB < C_RF) && (C_RF <= w_nc + C_WB) && w_r_ovl;
  assign w_l_vy  = clamp_vy((w_row_s - w_lc_s) >>> HIT_SHIFT);
  assign w_r_vy  = clamp_vy((w_row_s - w_rc_s) >>> HIT_SHIFT);

  // Free-running motion tick divider.
  always_ff @(posedge clk) begin
    if (rst || w_tick) begin
      r_tick_cnt <= '0;
    end else begin
      r_tick_cnt <= r_tick_cnt + 1'b1;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_n;
    end
  end

  // Next-state, ball motion, collision and scoring decisions.
  always_comb begin
    w_state_n   = r_state;
    w_wait_n    = r_wait_cnt;
    w_col_n     = r_col;
    w_row_n     = r_row;
    w_vy_n      = r_vy;
    w_dir_n     = r_dir;
    w_l_score_n = 1'b0;
    w_r_score_n = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_col_n  = C_HOME_COL;
        w_row_n  = C_HOME_ROW;
        w_wait_n = '0;
        if (bus.serve) begin
          w_state_n = S_WAIT;
        end
      end
      S_WAIT: begin
        if (w_tick) begin
          if (w_wait_done) begin
            w_state_n = S_PLAY;
            w_wait_n  = '0;
            w_vy_n    = -4'sd1;
          end else begin
            w_wait_n = r_wait_cnt + 1'b1;
          end
        end
      end
      S_PLAY: begin
        if (w_tick) begin
          // Vertical axis: reflect off the top wall or the score-bar edge.
          if (w_nr - C_HB <= 14'sd0) begin
            w_row_n = C_TOP_ROW;
            w_vy_n  = -r_vy;
          end else if (w_nr + C_HB >= C_FB) begin
            w_row_n = C_BOT_ROW;
            w_vy_n  = -r_vy;
          end else begin
            w_row_n = w_nr[11:0];
          end
          // Horizontal axis: paddle return beats a score on the same tick.
          if (w_l_hit) begin
            w_col_n = C_L_BOUNCE;
            w_dir_n = 1'b1;
            w_vy_n  = w_l_vy;
          end else if (w_r_hit) begin
            w_col_n = C_R_BOUNCE;
            w_dir_n = 1'b0;
            w_vy_n  = w_r_vy;
          end else if (w_nc - C_WB <= 14'sd0) begin
            w_r_score_n = 1'b1;
            w_dir_n     = 1'b0;
            w_state_n   = S_IDLE;
            w_col_n     = C_HOME_COL;
            w_row_n     = C_HOME_ROW;
          end else if (w_nc + C_WB >= C_COLS - 14'sd1) begin
            w_l_score_n = 1'b1;
            w_dir_n     = 1'b1;
            w_state_n   = S_IDLE;
            w_col_n     = C_HOME_COL;
            w_row_n     = C_HOME_ROW;
          end else begin
            w_col_n = w_nc[11:0];
          end
        end
      end
      default: begin
        w_state_n = S_IDLE;
      end
    endcase
  end

  // Ball position, velocity, serve delay and score pulse registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wait_cnt <= '0;
      r_col      <= C_HOME_COL;
      r_row      <= C_HOME_ROW;
      r_vy       <= -4'sd1;
      r_dir      <= 1'b1;
      r_l_score  <= 1'b0;
      r_r_score  <= 1'b0;
    end else begin
      r_wait_cnt <= w_wait_n;
      r_col      <= w_col_n;
      r_row      <= w_row_n;
      r_vy       <= w_vy_n;
      r_dir      <= w_dir_n;
      r_l_score  <= w_l_score_n;
      r_r_score  <= w_r_score_n;
    end
  end

`ifdef BALL_SPEEDUP_EN
  logic             r_speed;
  logic [SPD_W-1:0] r_speed_x;
  logic             w_launch;
  logic             w_hit;

  assign w_launch = w_tick && (r_state == S_WAIT) && w_wait_done;
  assign w_hit    = w_tick && (r_state == S_PLAY) && (w_l_hit || w_r_hit);
  assign r_speed  = 1'b0;

  // Each paddle return quickens the ball up to MAX_VX; every launch starts slow.
  always_ff @(posedge clk) begin
    if (rst || w_launch) begin
      r_speed_x <= SPD_W'(1);
    end else if (w_hit && (r_speed_x < SPD_W'(MAX_VX))) begin
      r_speed_x <= r_speed_x + 1'b1;
    end
  end

  assign w_speed = r_speed_x | SPD_W'(r_speed);
`else
  assign w_speed = SPD_W'(1);
`endif

  assign bus.ball_center_col = r_col;
  assign bus.ball_center_row = r_row;
  assign bus.ball_active     = (r_state == S_PLAY);
  assign bus.l_score         = r_l_score;
  assign bus.r_score         = r_r_score;
  assign o_dbg_state         = r_state;

endmodule

// File: tb/tb_ball_physics.sv
// Self-checking bench for ball_physics (TICK_DIV=4, SERVE_DELAY=2).
// A tick-level game model tracks the ball; every tick the DUT position,
// activity and score pulses are compared with it. A table of paddle
// encounters drives hit offsets and misses with known outcomes, followed
// by random encounters, an ignored mid-rally serve and a mid-rally reset.
module tb_ball_physics;
  localparam int TD       = 4;
  localparam int SD       = 2;
  localparam int COLS     = 800;
  localparam int FB       = 560;
  localparam int HB       = 4;
  localparam int WB       = 3;
  localparam int PH2      = 22;
  localparam int LF       = 21;
  localparam int RF       = 779;
  localparam int HOME_COL = 400;
  localparam int HOME_ROW = 300;
  localparam int MAXVY    = 3;
  localparam int MAXVX    = 4;
  localparam int HSH      = 3;
  localparam int L_BOUNCE = 25;
  localparam int R_BOUNCE = 775;
  localparam int BUDGET   = 1000;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] dbg_state;

  ball_physics_if bus ();

  ball_physics #(.TICK_DIV(TD), .SERVE_DELAY(SD)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Game model state (0 idle, 1 wait, 2 play)
  int m_st, m_col, m_row, m_vy, m_dir, m_spd, m_wait;
  bit m_ls, m_rs, m_hit, m_score;
  int m_hit_off;
  int m_lsc = 0;
  int m_rsc = 0;
  int lc = 300;
  int rc = 300;

  // Encounter plan for the receiving paddle
  bit plan_miss = 1'b0;
  int plan_off  = 0;

  // Pulse-width monitor
  int l_pulse_cyc = 0;
  int r_pulse_cyc = 0;
  always @(negedge clk) begin
    if (bus.l_score === 1'b1) l_pulse_cyc++;
    if (bus.r_score === 1'b1) r_pulse_cyc++;
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit overlaps(input int r, input int p);
    return (r - p <= HB + PH2) && (p - r <= HB + PH2);
  endfunction

  // Deflection zone: floor of offset over zone height, limited to +-MAXVY.
  function automatic int deflect(input int d);
    int z;
    int q;
    z = 1 << HSH;
    q = (d >= 0) ? d / z : -((-d + z - 1) / z);
    if (q > MAXVY) q = MAXVY;
    if (q < -MAXVY) q = -MAXVY;
    return q;
  endfunction

  task automatic model_reset();
    m_st = 0; m_col = HOME_COL; m_row = HOME_ROW; m_vy = -1;
    m_dir = 1; m_spd = 1; m_wait = 0;
    m_ls = 0; m_rs = 0; m_hit = 0; m_score = 0;
  endtask

  task automatic model_serve();
    if (m_st == 0) begin
      m_st = 1;
      m_wait = 0;
    end
  endtask

  task automatic model_tick();
    int nc, nr, nvy, r0;
    bit lh, rh;
    m_ls = 0; m_rs = 0; m_hit = 0; m_score = 0;
    if (m_st == 0) begin
      m_col = HOME_COL;
      m_row = HOME_ROW;
    end else if (m_st == 1) begin
      m_wait++;
      if (m_wait == SD) begin
        m_st = 2; m_vy = -1; m_spd = 1;
      end
    end else begin
      r0  = m_row;
      nc  = m_dir ? m_col + m_spd : m_col - m_spd;
      nr  = m_row + m_vy;
      nvy = m_vy;
      if (nr - HB <= 0) begin
        nr = HB; nvy = -m_vy;
      end else if (nr + HB >= FB) begin
        nr = FB - HB; nvy = -m_vy;
      end
      lh = (m_dir == 0) && (m_col - WB > LF) && (LF >= nc - WB) && overlaps(r0, lc);
      rh = (m_dir == 1) && (m_col + WB < RF) && (RF <= nc + WB) && overlaps(r0, rc);
      m_row = nr;
      m_vy  = nvy;
      if (lh || rh) begin
        m_hit     = 1;
        m_hit_off = lh ? r0 - lc : r0 - rc;
        m_vy      = deflect(m_hit_off);
        m_col     = lh ? L_BOUNCE : R_BOUNCE;
        m_dir     = lh ? 1 : 0;
`ifdef BALL_SPEEDUP_EN
        if (m_spd < MAXVX) m_spd++;
`endif
      end else if (nc - WB <= 0 || nc + WB >= COLS - 1) begin
        m_score = 1;
        if (nc - WB <= 0) begin
          m_rs = 1; m_rsc++; m_dir = 0;
        end else begin
          m_ls = 1; m_lsc++; m_dir = 1;
        end
        m_st = 0; m_col = HOME_COL; m_row = HOME_ROW;
      end else begin
        m_col = nc;
      end
    end
  endtask

  task automatic compare();
    check("col", bus.ball_center_col, m_col);
    check("row", bus.ball_center_row, m_row);
    check("active", bus.ball_active, (m_st == 2));
    check("l_score", bus.l_score, m_ls);
    check("r_score", bus.r_score, m_rs);
  endtask

  // Receiving paddle follows the plan; the other one wanders randomly.
  task automatic drive_paddles();
    int c;
    if (plan_miss) c = (m_row >= 300) ? m_row - 100 : m_row + 100;
    else c = m_row - plan_off;
    if (c < 0) c = 0;
    if (m_dir == 1) begin
      rc = c; lc = $urandom_range(0, 599);
    end else begin
      lc = c; rc = $urandom_range(0, 599);
    end
    bus.l_center_row = 12'(lc);
    bus.r_center_row = 12'(rc);
  endtask

  // All step tasks start and end 1 time unit after a tick edge.
  task automatic step();
    repeat (TD) @(posedge clk);
    #1;
    model_tick();
    compare();
    drive_paddles();
  endtask

  task automatic serve_step();
    bus.serve = 1'b1;
    @(posedge clk);
    #1;
    bus.serve = 1'b0;
    repeat (TD - 1) @(posedge clk);
    #1;
    model_serve();
    model_tick();
    compare();
    drive_paddles();
  endtask

  task automatic encounter(input bit miss, input int off);
    int n;
    n = 0;
    plan_miss = miss;
    plan_off  = off;
    drive_paddles();
    do begin
      step();
      n++;
    end while (!m_hit && !m_score && n < BUDGET);
    if (!m_hit && !m_score) begin
      total++;
      bad++;
      $display("FAIL encounter_timeout: no hit or score after %0d ticks", n);
    end
  endtask

  typedef struct {
    bit side;     // 1 = right paddle receives
    bit miss;
    int off;      // ball row minus paddle centre at the crossing tick
    int exp_vy;
  } vec_t;

  vec_t vecs[15];

  initial begin
    vec_t v;
    int   hit_row;
    int   hit_off;

    vecs[0]  = '{1'b1, 1'b0,   0,  0};
    vecs[1]  = '{1'b0, 1'b0,   0,  0};
    vecs[2]  = '{1'b1, 1'b0,  20,  2};
    vecs[3]  = '{1'b0, 1'b0,  20,  2};
    vecs[4]  = '{1'b1, 1'b0,  26,  3};
    vecs[5]  = '{1'b0, 1'b0, -26, -3};
    vecs[6]  = '{1'b1, 1'b0,  -9, -2};
    vecs[7]  = '{1'b0, 1'b0,  -8, -1};
    vecs[8]  = '{1'b1, 1'b0, -25, -3};
    vecs[9]  = '{1'b0, 1'b1,   0,  0};
    vecs[10] = '{1'b0, 1'b0,   7,  0};
    vecs[11] = '{1'b1, 1'b1,   0,  0};
    vecs[12] = '{1'b1, 1'b0,  -1, -1};
    vecs[13] = '{1'b0, 1'b0,  13,  1};
    vecs[14] = '{1'b1, 1'b1,   0,  0};

    // Reset
    rst = 1'b1;
    bus.serve = 1'b0;
    bus.l_center_row = 12'd300;
    bus.r_center_row = 12'd300;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    compare();
    check("dbg_idle", dbg_state, 0);

    // Parked ball ignores time until served
    step();
    step();

    // Table-driven encounters
    for (int i = 0; i < 15; i++) begin
      v = vecs[i];
      if (m_st == 0) serve_step();
      encounter(v.miss, v.off);
      if (v.miss) begin
        check($sformatf("v%0d_l_score", i), bus.l_score, v.side);
        check($sformatf("v%0d_r_score", i), bus.r_score, !v.side);
        check($sformatf("v%0d_home_col", i), bus.ball_center_col, HOME_COL);
      end else begin
        check($sformatf("v%0d_bounce_col", i), bus.ball_center_col,
              v.side ? R_BOUNCE : L_BOUNCE);
        hit_row = m_row;
        hit_off = m_hit_off;
        step();
        if (hit_off == v.off && hit_row + v.exp_vy - HB > 0 && hit_row + v.exp_vy + HB < FB)
          check($sformatf("v%0d_deflect_vy", i), int'(bus.ball_center_row) - hit_row, v.exp_vy);
      end
    end

    // Random encounters with an ignored serve in the middle of a rally
    for (int i = 0; i < 6; i++) begin
      if (m_st == 0) serve_step();
      if (i == 2) begin
        repeat (10) step();
        serve_step();
      end
      encounter($urandom_range(0, 4) == 0, int'($urandom_range(0, 60)) - 30);
    end

    // Reset in the middle of a rally
    if (m_st == 0) serve_step();
    repeat (40) step();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    compare();
    repeat (5) step();
    serve_step();
    repeat (60) step();

    // Pulse widths: one clk per score event
    check("l_pulse_cycles", l_pulse_cyc, m_lsc);
    check("r_pulse_cycles", r_pulse_cyc, m_rsc);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
